ucie_ctl_parity_checker: RTL and testbench

- Receive-side sideband parity checker, the counterpart of the transmit parity generator.
- Assembles an incoming sideband packet from serialised 32-bit phases: header phase0, header phase1, then optional data phase2 and phase3.
- Recomputes control parity (CP) and data parity (DP) and compares them with the CP/DP bits carried in header phase1.
- Reports the per-packet result and keeps a saturating error counter. Sits between the SB deserialiser and the SB packet decoder.

---
 rtl/ucie_ctl_parity_checker.sv | 107 ++++++++++
 tb/tb_ucie_ctl_parity_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_parity_checker.sv
// Sideband RX parity checker: assembles 2- or 4-phase packets, recomputes CP/DP
// against the bits carried in phase1, and keeps a saturating error counter.
module ucie_ctl_parity_checker #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_phase_valid,
   input  logic [31:0]      i_phase,
   input  logic             i_sop,
   input  logic             i_has_data,
   input  logic             i_err_clr,
   output logic             o_pkt_valid,
   output logic [63:0]      o_pkt_hdr,
   output logic [63:0]      o_pkt_data,
   output logic             o_pkt_has_data,
   output logic             o_cp_err,
   output logic             o_dp_err,
   output logic             o_proto_err,
   output logic [CNT_W-1:0] o_err_cnt
);

   typedef enum logic [1:0] {IDLE, HDR1, DAT0, DAT1} state_t;

   state_t           state_q;
   logic [31:0]      ph0_q, ph1_q, ph2_q;
   logic             has_data_q;
   logic             pkt_valid_q, proto_q, pkt_has_q, cp_q, dp_q;
   logic [63:0]      hdr_q, data_q;
   logic [CNT_W-1:0] cnt_q;

   logic        finish;
   logic [31:0] ph1_w;
   logic        cp_err_d, dp_err_d;

   // The finishing phase is still on i_phase, so parity folds it in directly.
   assign finish   = i_phase_valid && !i_sop &&
                     (((state_q == HDR1) && !has_data_q) || (state_q == DAT1));
   assign ph1_w    = (state_q == HDR1) ? i_phase : ph1_q;
   assign cp_err_d = ph1_w[30] != (^{ph0_q, ph1_w[29:0]});
   assign dp_err_d = ph1_w[31] != ((state_q == DAT1) ? (^{ph2_q, i_phase}) : 1'b0);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q     <= IDLE;
         ph0_q       <= '0;
         ph1_q       <= '0;
         ph2_q       <= '0;
         has_data_q  <= 1'b0;
         pkt_valid_q <= 1'b0;
         proto_q     <= 1'b0;
         pkt_has_q   <= 1'b0;
         cp_q        <= 1'b0;
         dp_q        <= 1'b0;
         hdr_q       <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
      end else begin
         pkt_valid_q <= 1'b0;
         proto_q     <= 1'b0;
         if (i_err_clr) cnt_q <= '0;
         if (i_phase_valid) begin
            if (i_sop) begin
               proto_q    <= (state_q != IDLE);
               ph0_q      <= i_phase;
               has_data_q <= i_has_data;
               state_q    <= HDR1;
            end else begin
               case (state_q)
                  IDLE: proto_q <= 1'b1;
                  HDR1: begin
                     ph1_q   <= i_phase;
                     state_q <= has_data_q ? DAT0 : IDLE;
                  end
                  DAT0: begin
                     ph2_q   <= i_phase;
                     state_q <= DAT1;
                  end
                  DAT1: state_q <= IDLE;
                  default: state_q <= IDLE;
               endcase
            end
            if (finish) begin
               pkt_valid_q <= 1'b1;
               hdr_q       <= {ph0_q, ph1_w};
               data_q      <= has_data_q ? {ph2_q, i_phase} : 64'd0;
               pkt_has_q   <= has_data_q;
               cp_q        <= cp_err_d;
               dp_q        <= dp_err_d;
               // A clear in the same cycle wins over counting this packet.
               if (!i_err_clr && (cp_err_d || dp_err_d) && (cnt_q != '1))
                  cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign o_pkt_valid    = pkt_valid_q;
   assign o_pkt_hdr      = hdr_q;
   assign o_pkt_data     = data_q;
   assign o_pkt_has_data = pkt_has_q;
   assign o_cp_err       = cp_q;
   assign o_dp_err       = dp_q;
   assign o_proto_err    = proto_q;
   assign o_err_cnt      = cnt_q;

endmodule

// File: tb/tb_ucie_ctl_parity_checker.sv
// Scoreboard bench for ucie_ctl_parity_checker: a packet-level model predicts
// results/protocol pulses; a negedge monitor pops and compares them.
module tb_ucie_ctl_parity_checker;

   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             i_rst, i_phase_valid, i_sop, i_has_data, i_err_clr;
   logic [31:0]      i_phase;
   logic             o_pkt_valid, o_pkt_has_data, o_cp_err, o_dp_err, o_proto_err;
   logic [63:0]      o_pkt_hdr, o_pkt_data;
   logic [CNT_W-1:0] o_err_cnt;

   ucie_ctl_parity_checker #(.CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_phase_valid(i_phase_valid), .i_phase(i_phase),
      .i_sop(i_sop), .i_has_data(i_has_data), .i_err_clr(i_err_clr),
      .o_pkt_valid(o_pkt_valid), .o_pkt_hdr(o_pkt_hdr), .o_pkt_data(o_pkt_data),
      .o_pkt_has_data(o_pkt_has_data), .o_cp_err(o_cp_err), .o_dp_err(o_dp_err),
      .o_proto_err(o_proto_err), .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_pkt;
      logic [63:0] hdr, data;
      bit          hd, cp, dp;
      int          cnt;
   } exp_t;

   exp_t        q[$];
   logic [31:0] cur[$];
   bit          cur_hd;
   int          m_cnt;
   int          total = 0, bad = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit par(logic [63:0] v);
      return bit'($countones(v) % 2);
   endfunction

   // Packet-level reference: tracks the phases of the packet in flight.
   task automatic model(bit v, bit sop, bit hd, logic [31:0] p, bit clr);
      exp_t e;
      bit   fin = 0, err = 0;
      if (v) begin
         if (sop) begin
            if (cur.size() > 0) begin e = '{default: 0}; q.push_back(e); end
            cur.delete();
            cur.push_back(p);
            cur_hd = hd;
         end else if (cur.size() == 0) begin
            e = '{default: 0};
            q.push_back(e);
         end else begin
            cur.push_back(p);
            if (cur.size() == (cur_hd ? 4 : 2)) begin
               fin      = 1;
               e.is_pkt = 1;
               e.hdr    = {cur[0], cur[1]};
               e.data   = cur_hd ? {cur[2], cur[3]} : 64'd0;
               e.hd     = cur_hd;
               e.cp     = cur[1][30] != par({32'd0, cur[0]} ^ {34'd0, cur[1][29:0]});
               e.dp     = cur[1][31] != (cur_hd ? par({cur[2], cur[3]}) : 1'b0);
               err      = e.cp | e.dp;
               cur.delete();
            end
         end
      end
      if (clr) m_cnt = 0;
      else if (fin && err && m_cnt < CMAX) m_cnt++;
      if (fin) begin e.cnt = m_cnt; q.push_back(e); end
   endtask

   task automatic step(bit v, bit sop, bit hd, logic [31:0] p, bit clr);
      i_phase_valid = v; i_sop = sop; i_has_data = hd; i_phase = p; i_err_clr = clr;
      model(v, sop, hd, p, clr);
      @(posedge clk); #1;
   endtask

   task automatic gap(int n);
      for (int i = 0; i < n; i++)
         step(0, 1'($urandom), 1'($urandom), $urandom, 0);
   endtask

   function automatic logic [31:0] mk_p1(logic [31:0] p0, logic [29:0] lo,
                                         logic [31:0] p2, logic [31:0] p3,
                                         bit hd, bit fcp, bit fdp);
      bit cp = par({32'd0, p0} ^ {34'd0, lo}) ^ fcp;
      bit dp = (hd ? par({p2, p3}) : 1'b0) ^ fdp;
      return {dp, cp, lo};
   endfunction

   // nph < full length truncates the packet (the next SOP aborts it).
   task automatic send_pkt(logic [31:0] p0, logic [31:0] p1, logic [31:0] p2,
                           logic [31:0] p3, bit hd, int maxgap, bit clr_last, int nph);
      logic [31:0] ph[4];
      int          n = hd ? 4 : 2;
      ph[0] = p0; ph[1] = p1; ph[2] = p2; ph[3] = p3;
      if (nph < n) n = nph;
      for (int i = 0; i < n; i++) begin
         if (maxgap > 0) gap($urandom_range(0, maxgap));
         step(1, i == 0, (i == 0) ? hd : 1'($urandom), ph[i],
              clr_last && (i == n - 1));
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b0;
      step(0, 0, 0, 32'd0, 0);
      cur.delete();
      m_cnt = 0;
      q.delete();
      chk("rst_pkt_valid", {63'd0, o_pkt_valid}, 64'd0);
      chk("rst_hdr", o_pkt_hdr, 64'd0);
      chk("rst_data", o_pkt_data, 64'd0);
      chk("rst_flags", {60'd0, o_pkt_has_data, o_cp_err, o_dp_err, o_proto_err}, 64'd0);
      chk("rst_cnt", {56'd0, o_err_cnt}, 64'd0);
      i_rst = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (o_pkt_valid === 1'b1 || o_proto_err === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_event", {62'd0, o_pkt_valid, o_proto_err}, 64'd0);
         end else begin
            e = q.pop_front();
            chk("event_kind", {62'd0, o_pkt_valid, o_proto_err},
                {62'd0, e.is_pkt, !e.is_pkt});
            if (e.is_pkt) begin
               chk("pkt_hdr", o_pkt_hdr, e.hdr);
               chk("pkt_data", o_pkt_data, e.data);
               chk("pkt_has_data", {63'd0, o_pkt_has_data}, {63'd0, e.hd});
               chk("cp_err", {63'd0, o_cp_err}, {63'd0, e.cp});
               chk("dp_err", {63'd0, o_dp_err}, {63'd0, e.dp});
               chk("err_cnt", {56'd0, o_err_cnt}, 64'(e.cnt));
            end
         end
      end
   end

   logic [31:0] bp0[8], bp1[8];

   initial begin
      logic [31:0] p0, p2, p3;
      bit          hd;
      i_rst = 1'b0; i_phase_valid = 0; i_sop = 0; i_has_data = 0; i_phase = 0; i_err_clr = 0;
      m_cnt = 0;
      @(posedge clk); #1;
      do_reset();

      // Header-only clean, then DP error data packet, then both flipped.
      send_pkt(32'h0000_0001, 32'h4000_0000, 0, 0, 0, 0, 0, 4);
      send_pkt(32'h0, 32'h8000_0000, 32'h3, 32'h0, 1, 0, 0, 4);
      p2 = $urandom; p3 = $urandom;
      send_pkt(32'h1234_5678, mk_p1(32'h1234_5678, 30'h155, p2, p3, 1, 1, 1), p2, p3, 1, 0, 0, 4);

      // Saturation.
      for (int i = 0; i < CMAX + 5; i++)
         send_pkt(i, mk_p1(i, 30'(i * 7), 0, 0, 0, 1, 0), 0, 0, 0, 0, 0, 2);
      chk("sat_cnt", {56'd0, o_err_cnt}, 64'(CMAX));
      step(0, 0, 0, 0, 1);
      chk("clr_cnt", {56'd0, o_err_cnt}, 64'd0);

      // SOP in DAT0 aborts; non-SOP in IDLE dropped.
      send_pkt(32'hAAAA_0000, 32'h0, 0, 0, 1, 0, 0, 2);
      send_pkt(32'h0F0F_0F0F, mk_p1(32'h0F0F_0F0F, 30'h3, 32'h5, 32'h9, 1, 0, 0), 32'h5, 32'h9, 1, 0, 0, 4);
      step(1, 0, 0, 32'hDEAD_BEEF, 0);
      send_pkt(32'h7, mk_p1(32'h7, 30'h1, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0, 2);

      // Same back-to-back stream, gapless then with random gaps.
      for (int i = 0; i < 8; i++) begin
         bp0[i] = $urandom;
         bp1[i] = mk_p1(bp0[i], 30'($urandom), 0, 0, 0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      end
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 8; i++) send_pkt(bp0[i], bp1[i], 0, 0, 0, r * 3, 0, 2);

      // Clear coincident with an erroring finish.
      send_pkt(32'h1, 32'h0, 0, 0, 0, 0, 1, 2);

      // Reset while in DAT1.
      send_pkt(32'h1, mk_p1(32'h1, 30'h2, 32'h3, 32'h4, 1, 0, 0), 32'h3, 0, 1, 0, 0, 3);
      do_reset();

      // Random traffic with gaps, truncations, stray phases and clears.
      for (int i = 0; i < 300; i++) begin
         hd = 1'($urandom);
         p0 = $urandom; p2 = $urandom; p3 = $urandom;
         if ($urandom_range(0, 9) == 0) step(1, 0, 1'($urandom), $urandom, 0);
         send_pkt(p0, mk_p1(p0, 30'($urandom), p2, p3, hd,
                            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)),
                  p2, p3, hd, 2, 1'($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 4);
         if ($urandom_range(0, 29) == 0) step(0, 0, 0, 0, 1);
      end

      repeat (3) step(0, 0, 0, 0, 0);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
